// File: rtl/wide_add_seq.sv
// rtl/wide_add_seq.sv - sequential multi-word adder driving a 16-bit Kogge-Stone slice adder
//
// ppa: 16-bit Kogge-Stone parallel-prefix adder, no carry-in.
//   A, B  : 16-bit operands
//   S     : 16-bit sum
//   CO    : carry-out
//
// wide_add_seq: computes {CO, S} = A + B + CI over W = 16*WORDS bits,
// one 16-bit slice per cycle, least-significant slice first.
//   CLK, RST            : clock (rising edge), asynchronous active-high reset
//   IN_VALID / IN_READY : operand handshake (A, B, CI)
//   OUT_VALID/OUT_READY : result handshake (S, CO)
//   S, CO               : registered W-bit sum and top-slice carry-out

module ppa (
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] S,
  output logic        CO
);

  logic [15:0] g_lvl [0:4];
  logic [15:0] p_lvl [0:4];

  always_comb begin
    g_lvl[0] = A & B;
    p_lvl[0] = A ^ B;
    for (int l = 1; l <= 4; l++) begin
      for (int i = 0; i < 16; i++) begin
        if (i >= (1 << (l - 1))) begin
          g_lvl[l][i] = g_lvl[l-1][i] | (p_lvl[l-1][i] & g_lvl[l-1][i - (1 << (l - 1))]);
          p_lvl[l][i] = p_lvl[l-1][i] & p_lvl[l-1][i - (1 << (l - 1))];
        end else begin
          g_lvl[l][i] = g_lvl[l-1][i];
          p_lvl[l][i] = p_lvl[l-1][i];
        end
      end
    end
    // After four levels g_lvl[4][i] is the carry out of bit i.
    S  = p_lvl[0] ^ {g_lvl[4][14:0], 1'b0};
    CO = g_lvl[4][15];
  end

endmodule

module wide_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [16*WORDS-1:0] A,
  input  logic [16*WORDS-1:0] B,
  input  logic                CI,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [16*WORDS-1:0] S,
  output logic                CO
);

  localparam int W  = 16 * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  s_q, s_d;
  logic          c_q, c_d;
  logic          co_q, co_d;
  logic [KW-1:0] k_q, k_d;

  logic [15:0] slice_a, slice_b, ppa_s, slice_sum;
  logic        ppa_co, slice_c;

  assign slice_a = a_q[{k_q, 4'h0} +: 16];
  assign slice_b = b_q[{k_q, 4'h0} +: 16];

  ppa u_ppa (
    .A  (slice_a),
    .B  (slice_b),
    .S  (ppa_s),
    .CO (ppa_co)
  );

  // ppa has no carry-in; the slice carry is folded in by an incrementer.
  // A carry can only come out of the increment when ppa produced all ones.
  assign slice_sum = ppa_s + {15'd0, c_q};
  assign slice_c   = ppa_co | (c_q & (ppa_s == 16'hFFFF));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    c_d     = c_q;
    co_d    = co_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          a_d     = A;
          b_d     = B;
          c_d     = CI;
          k_d     = '0;
          s_d     = '0;
          co_d    = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[{k_q, 4'h0} +: 16] = slice_sum;
        c_d                    = slice_c;
        if (k_q == K_LAST) begin
          co_d    = slice_c;
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        if (OUT_READY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      co_q    <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_q     <= c_d;
      co_q    <= co_d;
      k_q     <= k_d;
    end
  end

  // RST gates IN_READY directly so nothing is accepted while reset is held.
  assign IN_READY  = (state_q == IDLE) && !RST;
  assign OUT_VALID = (state_q == DONE);
  assign S         = s_q;
  assign CO        = co_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// tb/tb_wide_add_seq.sv - self-checking bench for wide_add_seq (WORDS=4 and WORDS=1)

module tb_wide_add_seq;

  logic        CLK;
  logic        RST;
  logic        sel4;
  logic        iv, rdy, ci_drv;
  logic [63:0] a_drv, b_drv;

  logic        ir4, ov4, co4, ir1, ov1, co1;
  logic [63:0] s4;
  logic [15:0] s1;

  logic        ir, ov, co_obs;
  logic [63:0] s_obs;

  int tests = 0;
  int fails = 0;
  logic [63:0] last_s;
  logic        last_co;

  wide_add_seq #(.WORDS(4)) dut4 (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (iv & sel4),
    .IN_READY  (ir4),
    .A         (a_drv),
    .B         (b_drv),
    .CI        (ci_drv),
    .OUT_VALID (ov4),
    .OUT_READY (rdy & sel4),
    .S         (s4),
    .CO        (co4)
  );

  wide_add_seq #(.WORDS(1)) dut1 (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (iv & ~sel4),
    .IN_READY  (ir1),
    .A         (a_drv[15:0]),
    .B         (b_drv[15:0]),
    .CI        (ci_drv),
    .OUT_VALID (ov1),
    .OUT_READY (rdy & ~sel4),
    .S         (s1),
    .CO        (co1)
  );

  assign ir     = sel4 ? ir4 : ir1;
  assign ov     = sel4 ? ov4 : ov1;
  assign co_obs = sel4 ? co4 : co1;
  assign s_obs  = sel4 ? s4 : {48'd0, s1};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction; expected result from plain integer addition.
  task automatic txn(input logic w4, input logic [63:0] av, input logic [63:0] bv,
                     input logic ci, input int gap);
    logic [64:0] full;
    logic [16:0] f1;
    logic [63:0] es;
    logic        ec;
    int          lat;
    sel4 = w4;
    full = {1'b0, av} + {1'b0, bv} + {64'd0, ci};
    f1   = {1'b0, av[15:0]} + {1'b0, bv[15:0]} + {16'd0, ci};
    if (w4) begin
      es = full[63:0];
      ec = full[64];
    end else begin
      es = {48'd0, f1[15:0]};
      ec = f1[16];
    end
    lat = 0;
    while (ir !== 1'b1 && lat < 20) begin
      @(posedge CLK); @(negedge CLK); lat++;
    end
    check("in_ready_idle", ir, 1);
    a_drv = av; b_drv = bv; ci_drv = ci; iv = 1'b1;
    rdy = (gap == 0);
    @(posedge CLK); @(negedge CLK);
    iv = 1'b0;
    a_drv = {$urandom, $urandom}; b_drv = {$urandom, $urandom}; ci_drv = 1'($urandom);
    check("in_ready_busy", ir, 0);
    lat = 0;
    while (ov !== 1'b1 && lat < 40) begin
      @(posedge CLK); lat++; @(negedge CLK);
    end
    check("latency", lat, w4 ? 4 : 1);
    check("sum", s_obs, {1'b0, es});
    check("carry", co_obs, ec);
    for (int i = 0; i < gap; i++) begin
      iv = 1'b1;
      a_drv = {$urandom, $urandom}; b_drv = {$urandom, $urandom}; ci_drv = 1'($urandom);
      @(posedge CLK); @(negedge CLK);
      check("hold_valid", ov, 1);
      check("hold_in_ready", ir, 0);
      check("hold_sum", s_obs, {1'b0, es});
      check("hold_carry", co_obs, ec);
    end
    iv = 1'b0;
    rdy = 1'b1;
    @(posedge CLK); @(negedge CLK);
    check("valid_drop", ov, 0);
    check("in_ready_after", ir, 1);
    rdy = 1'b0;
    last_s  = es;
    last_co = ec;
  endtask

  initial begin
    int lat;
    logic saw_ov;
    RST = 1'b1; iv = 1'b0; rdy = 1'b0; sel4 = 1'b1;
    a_drv = '0; b_drv = '0; ci_drv = 1'b0;

    repeat (2) @(negedge CLK);
    check("rst_in_ready", ir4, 0);
    check("rst_valid", ov4, 0);
    check("rst_sum", s4, 0);
    check("rst_carry", co4, 0);
    check("rst_in_ready_w1", ir1, 0);
    RST = 1'b0;
    @(negedge CLK);
    check("release_in_ready", ir4, 1);

    txn(1'b1, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 2);
    check("ripple_s", last_s, 64'h0000_0000_0001_0000);
    check("ripple_co", last_co, 0);

    txn(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1);
    check("inc_s", last_s, 64'h0);
    check("inc_co", last_co, 1);

    txn(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0);
    check("ones_s", last_s, 64'hFFFF_FFFF_FFFF_FFFF);
    check("ones_co", last_co, 1);

    txn(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 10);

    // Reset pulse during the second RUN cycle.
    sel4 = 1'b1;
    a_drv = 64'hFFFF_0000_FFFF_1234; b_drv = 64'h0000_FFFF_0001_1111; ci_drv = 1'b1;
    iv = 1'b1;
    @(posedge CLK); @(negedge CLK);
    iv = 1'b0;
    @(posedge CLK); @(negedge CLK);
    RST = 1'b1;
    #1;
    check("midrun_rst_valid", ov4, 0);
    check("midrun_rst_sum", s4, 0);
    check("midrun_rst_carry", co4, 0);
    check("midrun_rst_in_ready", ir4, 0);
    #1 RST = 1'b0;
    rdy = 1'b1;
    saw_ov = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); @(negedge CLK);
      if (ov4 === 1'b1) saw_ov = 1'b1;
    end
    rdy = 1'b0;
    check("midrun_no_valid", saw_ov, 0);
    check("midrun_idle", ir4, 1);

    txn(1'b1, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1);
    check("recover_s", last_s, 64'h2345_6789_ABCD_F001);
    check("recover_co", last_co, 0);

    // Reset while DONE is stalled by backpressure.
    a_drv = 64'h5; b_drv = 64'h7; ci_drv = 1'b0; iv = 1'b1;
    @(posedge CLK); @(negedge CLK);
    iv = 1'b0;
    lat = 0;
    while (ov4 !== 1'b1 && lat < 40) begin
      @(posedge CLK); lat++; @(negedge CLK);
    end
    check("done_rst_pre_valid", ov4, 1);
    RST = 1'b1;
    #1;
    check("done_rst_valid", ov4, 0);
    check("done_rst_sum", s4, 0);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("done_rst_in_ready", ir4, 1);

    for (int n = 0; n < 1000; n++) begin
      txn(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), $urandom_range(0, 3));
    end
    for (int n = 0; n < 1000; n++) begin
      txn(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
